ndp_unit_responder: RTL and testbench

Unit-side end of the NDP start/done handshake. It receives per-unit `ndp_start` pulses from the NDP controller and runs one timed operation per unit. For each unit it drives `ndp_status` (busy) and a one-cycle `ndp_done` pulse back to the controller. It sits beside the controller in the memops scheduler and stands in for up to eight near-data execution units: it is the execution model in simulation and the completion sequencer in hardware.

---
 rtl/ndp_unit_responder.sv | 103 ++++++++++
 tb/tb_ndp_unit_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ndp_unit_responder.sv
// Unit-side end of the NDP start/done handshake: one timed operation per unit,
// with a busy flag and a one-cycle done pulse per unit, plus shared counters.
module ndp_unit_responder #(
  parameter int NUM_UNITS = 8,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] ndp_start,
  input  logic [LEN_W-1:0]     start_len,
  input  logic [NUM_UNITS-1:0] abort,
  input  logic                 err_clear,
  output logic [NUM_UNITS-1:0] ndp_status,
  output logic [NUM_UNITS-1:0] ndp_done,
  output logic [NUM_UNITS-1:0] start_overrun,
  output logic [31:0]          done_count,
  output logic [15:0]          abort_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state  [NUM_UNITS];
  logic [LEN_W-1:0] remain [NUM_UNITS];

  logic [NUM_UNITS-1:0] busy_vec;
  logic [NUM_UNITS-1:0] abort_hit;
  logic [LEN_W-1:0]     load_len;
  logic [31:0]          done_inc;
  logic [15:0]          abort_inc;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    load_len  = (start_len == '0) ? LEN_W'(1) : start_len;
    busy_vec  = '0;
    abort_hit = '0;
    done_inc  = '0;
    abort_inc = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      busy_vec[i]  = (state[i] == S_BUSY);
      abort_hit[i] = busy_vec[i] & abort[i];
      done_inc     = done_inc + 32'(ndp_done[i]);
      abort_inc    = abort_inc + 16'(abort_hit[i]);
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the per-unit
  // arrays are small flop arrays, so they are cleared by reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        state[i]  <= S_IDLE;
        remain[i] <= '0;
      end
      ndp_status    <= '0;
      ndp_done      <= '0;
      start_overrun <= '0;
      done_count    <= '0;
      abort_count   <= '0;
    end else begin
      done_count  <= done_count + done_inc;
      abort_count <= abort_count + abort_inc;
      // A new overrun in the same cycle as err_clear keeps the flag set.
      start_overrun <= (start_overrun & ~{NUM_UNITS{err_clear}}) | (ndp_start & busy_vec);

      for (int i = 0; i < NUM_UNITS; i++) begin
        ndp_done[i] <= 1'b0;
        case (state[i])
          S_IDLE, S_DONE: begin
            if (ndp_start[i]) begin
              state[i]      <= S_BUSY;
              remain[i]     <= load_len;
              ndp_status[i] <= 1'b1;
            end else begin
              state[i]      <= S_IDLE;
              ndp_status[i] <= 1'b0;
            end
          end
          S_BUSY: begin
            if (abort[i]) begin
              state[i]      <= S_IDLE;
              ndp_status[i] <= 1'b0;
            end else if (remain[i] == LEN_W'(1)) begin
              state[i]      <= S_DONE;
              ndp_status[i] <= 1'b0;
              ndp_done[i]   <= 1'b1;
            end else begin
              remain[i] <= remain[i] - LEN_W'(1);
            end
          end
          default: begin
            state[i]      <= S_IDLE;
            ndp_status[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ndp_unit_responder.sv
// Self-checking bench for ndp_unit_responder: directed scenarios plus random
// traffic, compared every cycle against a timestamp-based operation model.
module tb_ndp_unit_responder;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ndp_start;
  logic [15:0]   start_len;
  logic [N-1:0]  abort;
  logic          err_clear;
  logic [N-1:0]  ndp_status;
  logic [N-1:0]  ndp_done;
  logic [N-1:0]  start_overrun;
  logic [31:0]   done_count;
  logic [15:0]   abort_count;

  ndp_unit_responder #(.NUM_UNITS(N), .LEN_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .ndp_start     (ndp_start),
    .start_len     (start_len),
    .abort         (abort),
    .err_clear     (err_clear),
    .ndp_status    (ndp_status),
    .ndp_done      (ndp_done),
    .start_overrun (start_overrun),
    .done_count    (done_count),
    .abort_count   (abort_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: cycle c is the interval after rising edge c. An operation accepted at
  // edge s with length L is busy in cycles s..s+L-1 and done in cycle s+L.
  int          cyc;
  int          m_start  [N];
  int          m_len    [N];
  bit          m_active [N];
  logic [N-1:0] m_ov;
  logic [31:0] m_done_cnt;
  logic [15:0] m_abort_cnt;

  function automatic logic [N-1:0] exp_status(input int c);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = m_active[i] && (c >= m_start[i]) && (c <= m_start[i] + m_len[i] - 1);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_done(input int c);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = m_active[i] && (c == m_start[i] + m_len[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_start[i]  = 0;
      m_len[i]    = 0;
    end
    m_ov        = '0;
    m_done_cnt  = '0;
    m_abort_cnt = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] st, input logic [15:0] len,
                            input logic [N-1:0] ab, input logic clr);
    logic [N-1:0] busy;
    logic [N-1:0] dn;
    int e;
    busy = exp_status(cyc);
    dn   = exp_done(cyc);
    e    = cyc + 1;
    m_done_cnt = m_done_cnt + 32'($countones(dn));
    for (int i = 0; i < N; i++) begin
      if (busy[i] && ab[i]) begin
        m_active[i] = 1'b0;
        m_abort_cnt = m_abort_cnt + 16'd1;
      end else if (st[i] && !busy[i]) begin
        m_active[i] = 1'b1;
        m_start[i]  = e;
        m_len[i]    = (len == 16'd0) ? 1 : int'(len);
      end
    end
    m_ov = (m_ov & ~{N{clr}}) | (st & busy);
    cyc  = e;
  endtask

  task automatic step(input logic [N-1:0] st, input logic [15:0] len,
                      input logic [N-1:0] ab, input logic clr);
    ndp_start = st;
    start_len = len;
    abort     = ab;
    err_clear = clr;
    @(posedge clk);
    model_edge(st, len, ab, clr);
    #1;
    check("status",        32'(ndp_status),    32'(exp_status(cyc)));
    check("done",          32'(ndp_done),      32'(exp_done(cyc)));
    check("start_overrun", 32'(start_overrun), 32'(m_ov));
    check("done_count",    done_count,         m_done_cnt);
    check("abort_count",   32'(abort_count),   32'(m_abort_cnt));
    ndp_start = '0;
    start_len = '0;
    abort     = '0;
    err_clear = 1'b0;
  endtask

  task automatic idle();
    step('0, 16'd0, '0, 1'b0);
  endtask

  // Step idle until ndp_done[unit] is seen, within a cycle budget.
  task automatic wait_done(input int unit, output int at, output bit seen);
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      idle();
      if (ndp_done[unit]) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    int  d1, d2, s0;
    int  cnt_a, cnt_b;
    bit  seen;
    logic [N-1:0] st, ab;

    reset     = 1'b1;
    ndp_start = '0;
    start_len = '0;
    abort     = '0;
    err_clear = 1'b0;
    cyc       = 0;
    model_reset();

    #12;
    check("reset_status",   32'(ndp_status),    32'h0);
    check("reset_done",     32'(ndp_done),      32'h0);
    check("reset_overrun",  32'(start_overrun), 32'h0);
    check("reset_done_cnt", done_count,         32'h0);
    check("reset_abort_cnt", 32'(abort_count),  32'h0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Unit 0, length 4: four busy cycles, one done cycle, then done_count = 1.
    step(8'h01, 16'd4, '0, 1'b0);
    cnt_a = int'(ndp_status[0]);
    cnt_b = 0;
    repeat (6) begin
      idle();
      cnt_a += int'(ndp_status[0]);
      cnt_b += int'(ndp_done[0]);
    end
    check("t1_busy_cycles", 32'(cnt_a), 32'd4);
    check("t1_done_cycles", 32'(cnt_b), 32'd1);
    check("t1_done_count",  done_count, 32'd1);

    // Units 0 and 1, length 0 treated as 1.
    base = int'(done_count);
    step(8'h03, 16'd0, '0, 1'b0);
    check("t2_busy", 32'(ndp_status), 32'h03);
    idle();
    check("t2_done", 32'(ndp_done), 32'h03);
    repeat (2) idle();
    check("t2_done_count", done_count, 32'(base + 2));

    // Unit 2 overrun, done unaffected, err_clear afterwards.
    step(8'h04, 16'd5, '0, 1'b0);
    s0 = cyc;
    idle();
    step(8'h04, 16'd7, '0, 1'b0);
    wait_done(2, d1, seen);
    check("t3_done_seen",    32'(seen),          32'd1);
    check("t3_done_latency", 32'(d1 - s0),       32'd5);
    check("t3_overrun_held", 32'(start_overrun), 32'h04);
    idle();
    step('0, 16'd0, '0, 1'b1);
    check("t3_overrun_clr",  32'(start_overrun), 32'h00);

    // Unit 3 aborted in its third busy cycle, then a normal length-2 run.
    base = int'(abort_count);
    step(8'h08, 16'd10, '0, 1'b0);
    idle();
    idle();
    step('0, 16'd0, 8'h08, 1'b0);
    check("t4_status_fall", 32'(ndp_status[3]), 32'd0);
    check("t4_abort_count", 32'(abort_count),   32'(base + 1));
    cnt_b = 0;
    repeat (12) begin
      idle();
      cnt_b += int'(ndp_done[3]);
    end
    check("t4_no_done", 32'(cnt_b), 32'd0);
    step(8'h08, 16'd2, '0, 1'b0);
    s0 = cyc;
    wait_done(3, d1, seen);
    check("t4_restart_seen",    32'(seen),    32'd1);
    check("t4_restart_latency", 32'(d1 - s0), 32'd2);

    // Back-to-back on unit 0, length 3: dones exactly 4 cycles apart.
    step(8'h01, 16'd3, '0, 1'b0);
    wait_done(0, d1, seen);
    check("t5_first_seen", 32'(seen), 32'd1);
    step(8'h01, 16'd3, '0, 1'b0);
    check("t5_rebusy", 32'(ndp_status[0]), 32'd1);
    wait_done(0, d2, seen);
    check("t5_second_seen", 32'(seen),    32'd1);
    check("t5_period",      32'(d2 - d1), 32'd4);
    repeat (2) idle();

    // Asynchronous reset while units 0 and 7 are busy.
    step(8'h81, 16'd20, '0, 1'b0);
    idle();
    idle();
    check("t6_busy_before", 32'(ndp_status), 32'h81);
    #2 reset = 1'b1;
    #1;
    check("t6_status",    32'(ndp_status),    32'h0);
    check("t6_done",      32'(ndp_done),      32'h0);
    check("t6_overrun",   32'(start_overrun), 32'h0);
    check("t6_done_cnt",  done_count,         32'h0);
    check("t6_abort_cnt", 32'(abort_count),   32'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    cnt_b = 0;
    repeat (25) begin
      idle();
      cnt_b += $countones(ndp_done);
    end
    check("t6_no_done_after", 32'(cnt_b), 32'd0);

    // Random traffic against the model.
    repeat (500) begin
      st = N'($urandom & $urandom & $urandom);
      ab = ($urandom_range(0, 7) == 0) ? N'($urandom & $urandom) : '0;
      step(st, 16'($urandom_range(0, 6)), ab, ($urandom_range(0, 15) == 0));
    end
    repeat (10) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
